seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
//  Sits directly upstream of the 4-bit-to-7-segment decoder: it drives the decoder's 4-bit
//  data input with one digit's nibble at a time and drives the active-low digit anodes itself.
//  Provides tear-free updates (frame-boundary commit), inter-digit blanking against ghosting,
//  and optional leading-zero suppression.
// PARAMETERS
//  NUM_DIGITS    4     number of digits scanned (>=2)
//  REFRESH_DIV   1000  clocks per digit slot, blank time included (>=2)
//  BLANK_CYCLES  16    clocks at slot start with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)
//  LZ_SUPPRESS   1     1 = blank leading zero digits; digit 0 is never suppressed
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               asynchronous, active-low reset
//  enable      in   1               1 = scan running, 0 = display off
//  load        in   1               1-cycle strobe: sample value
//  value       in   4*NUM_DIGITS    packed nibbles; [3:0] = digit 0 (rightmost)
//  data        out  4               nibble to the segment decoder, registered
//  an_n        out  NUM_DIGITS      active-low anode select; an_n[i] drives digit i
//  frame_done  out  1               1-cycle pulse when the last digit slot ends
//  pending     out  1               1 = shadow value waiting for frame-boundary commit
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; div_cnt=0; idx=0; active=0; shadow=0;
//   data=4'h0; an_n=all 1s; frame_done=0; pending=0. Outputs change without a clock edge.
//  States: IDLE, BLANK, SHOW. All outputs are registered.
//   IDLE: an_n all 1s. enable=1 -> BLANK with idx=0, div_cnt=0.
//   BLANK: an_n all 1s; data = active nibble[idx]; div_cnt increments each clock.
//     div_cnt==BLANK_CYCLES-1 -> SHOW. BLANK_CYCLES=0 skips BLANK entirely.
//   SHOW: an_n[idx]=0 (others 1) unless idx is suppressed. data is held.
//     div_cnt==REFRESH_DIV-1 -> div_cnt=0, idx=idx+1, state BLANK (or SHOW if BLANK_CYCLES=0).
//  Wrap: when idx==NUM_DIGITS-1 ends, idx->0 and frame_done=1 for that one cycle.
//   If pending=1, shadow is copied to active and pending clears.
//  Slot length: exactly REFRESH_DIV clocks. Frame length: NUM_DIGITS*REFRESH_DIV clocks.
//  load in IDLE: value is written straight to active; pending stays 0.
//  load while scanning: value -> shadow, pending=1. A later load before the wrap overwrites shadow.
//  load in the same cycle as a wrap: value goes straight to active, shadow is unchanged, pending=0.
//  Leading-zero suppression (LZ_SUPPRESS=1): digit i>0 is suppressed when active nibbles i..N-1
//   are all zero. A suppressed digit keeps its slot timing, with an_n all 1s for the slot.
//  enable 1->0 in any state: next clock -> IDLE, an_n all 1s, idx=0, div_cnt=0, frame_done=0.
//   active, shadow and pending are retained.
//  Re-enable restarts at digit 0, BLANK phase. A retained pending value commits at the next wrap.
//  Exactly one anode is ever low at a time; none is low outside SHOW.
//  Nibble values A-F are passed through unchanged; decoding is the downstream decoder's job.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, LZ_SUPPRESS=1 unless stated)
//  1. Reset: assert rst_n=0 mid-SHOW -> an_n=4'b1111, data=0, pending=0 at once, without a clock edge.
//  2. enable=0, load 16'h1234, then enable=1 -> repeating per-slot pattern:
//     2 clocks an_n=1111, then 6 clocks of an_n=1110/1101/1011/0111 with data=4/3/2/1.
//     frame_done pulses every 32 clocks.
//  3. While scanning 1234, load 16'hABCD during digit 1 -> pending=1; rest of the frame still shows
//     1234; at the wrap pending=0, and the next frame shows D,C,B,A.
//  4. load 16'h0050 -> slots 3 and 2 show an_n=1111; digits 1,0 show 5,0.
//     load 16'h0000 -> only digit 0 lit, showing 0.
//     With LZ_SUPPRESS=0, 16'h0050 lights all four digits.
//  5. Drop enable during digit 2 SHOW -> next clock an_n=1111, frame_done stays 0.
//     enable=1 again -> scan resumes at digit 0 after 2 blank clocks.
//  6. load asserted on the exact wrap cycle -> new value shown from digit 0 of the next frame,
//     pending never set. Also check BLANK_CYCLES=0: an_n is never 1111 between digits.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit 7-segment display. It drives one nibble at
// a time to the segment decoder, blanks between digits, commits new values only at frame wrap.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              data,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] DIV_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [1:0]    S_SLOT0    = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [3:0]            data_q, data_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] lz_d;
  logic                  tail;

  // Sequencing: slot = BLANK_CYCLES blank clocks followed by SHOW up to REFRESH_DIV total.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      div_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SLOT0;
          div_d   = '0;
          idx_d   = '0;
        end
        S_BLANK: begin
          div_d = div_q + 1'b1;
          if (div_q == BLANK_LAST) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = S_SLOT0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          div_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Value capture: direct while idle or on the wrap itself, otherwise staged in the shadow.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (state_q == S_IDLE) begin
      if (load) active_d = value;
    end else if (wrap) begin
      if (load)           active_d = value;
      else if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always lights.
  always_comb begin
    tail = 1'b1;
    lz_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail = tail & (active_d[4*i +: 4] == 4'h0);
      if (i > 0 && LZ_SUPPRESS != 0) lz_d[i] = tail;
    end
  end

  always_comb begin
    fd_d   = wrap;
    data_d = (state_d != S_IDLE) ? active_d[{idx_d, 2'b00} +: 4] : data_q;
    an_d   = '1;
    if (state_d == S_SHOW && !lz_d[idx_d]) an_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      data_q    <= 4'h0;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign data       = data_q;
  assign an_n       = an_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: three variants (normal, no blank, no suppression) share one
// scan-time model; directed scenarios pin the model, then random stimulus runs against it.
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int B  = 2;
  localparam int FR = N * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        cmp_on = 1'b0;

  logic [3:0] data_a, data_z, data_nz;
  logic [3:0] an_a, an_z, an_nz;
  logic       fd_a, fd_z, fd_nz;
  logic       pend_a, pend_z, pend_nz;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .data(data_a), .an_n(an_a), .frame_done(fd_a), .pending(pend_a));
  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0), .LZ_SUPPRESS(1)) u_z (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .data(data_z), .an_n(an_z), .frame_done(fd_z), .pending(pend_z));
  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(0)) u_nz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .data(data_nz), .an_n(an_nz), .frame_done(fd_nz), .pending(pend_nz));

  always #5 clk = ~clk;

  // t = clocks since the scan (re)started, -1 when idle.
  typedef struct packed {
    int          t;
    logic [15:0] act;
    logic [15:0] shd;
    logic        pend;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t cur, logic en, logic ld, logic [15:0] v);
    mdl_t n;
    n = cur;
    if (!en) begin
      if (ld) begin
        if (cur.t >= 0) begin n.shd = v; n.pend = 1'b1; end
        else n.act = v;
      end
      n.t = -1;
    end else if (cur.t < 0) begin
      n.t = 0;
      if (ld) n.act = v;
    end else begin
      n.t = cur.t + 1;
      if (n.t % FR == 0) begin
        if (ld) n.act = v;
        else if (cur.pend) n.act = cur.shd;
        n.pend = 1'b0;
      end else if (ld) begin
        n.shd = v; n.pend = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_an(mdl_t cur, int blank, bit lz);
    int slot;
    logic [15:0] hi;
    if (cur.t < 0) return 4'hF;
    slot = (cur.t / R) % N;
    if (cur.t % R < blank) return 4'hF;
    hi = cur.act >> (4 * slot);
    if (lz && slot > 0 && hi == 16'h0) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [3:0] exp_data(mdl_t cur);
    logic [15:0] hi;
    hi = cur.act >> (4 * ((cur.t / R) % N));
    return hi[3:0];
  endfunction

  function automatic logic exp_fd(mdl_t cur);
    return (cur.t > 0) && (cur.t % FR == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{t: -1, act: 16'h0, shd: 16'h0, pend: 1'b0};
    else        m <= step(m, enable, load, value);
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, got, exp, m.t, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("an_a", an_a, exp_an(m, B, 1'b1));
      chk("an_z", an_z, exp_an(m, 0, 1'b1));
      chk("an_nz", an_nz, exp_an(m, B, 1'b0));
      chk("fd_a", fd_a, exp_fd(m));
      chk("fd_z", fd_z, exp_fd(m));
      chk("fd_nz", fd_nz, exp_fd(m));
      chk("pend_a", pend_a, m.pend);
      chk("pend_z", pend_z, m.pend);
      chk("pend_nz", pend_nz, m.pend);
      if (m.t >= 0) begin
        chk("data_a", data_a, exp_data(m));
        chk("data_z", data_z, exp_data(m));
        chk("data_nz", data_nz, exp_data(m));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rv;
    repeat (3) tick();
    chk("rst_an", an_a, 4'hF);
    chk("rst_data", data_a, 4'h0);
    chk("rst_pend", pend_a, 1'b0);
    chk("rst_fd", fd_a, 1'b0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Idle load then start scanning 1234
    value = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1; tick();
    chk("t0_an", an_a, 4'hF);
    chk("t0_an_z", an_z, 4'b1110);
    repeat (2) tick();
    chk("d0_an", an_a, 4'b1110);
    chk("d0_data", data_a, 4'h4);
    repeat (6) tick();
    chk("d1_blank_an", an_a, 4'hF);
    chk("d1_data", data_a, 4'h3);
    repeat (2) tick();
    chk("d1_an", an_a, 4'b1101);
    repeat (21) tick();
    chk("fd_before", fd_a, 1'b0);
    tick();
    chk("fd_wrap", fd_a, 1'b1);
    chk("wrap_data", data_a, 4'h4);

    // Mid-frame load is staged until the wrap
    repeat (9) tick();
    value = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
    chk("stage_pend", pend_a, 1'b1);
    chk("stage_data", data_a, 4'h3);
    repeat (21) tick();
    chk("d3_an", an_a, 4'b0111);
    chk("d3_data", data_a, 4'h1);
    tick();
    chk("commit_pend", pend_a, 1'b0);
    chk("commit_data", data_a, 4'hD);

    // Leading-zero suppression with 0050
    repeat (2) tick();
    value = 16'h0050; load = 1'b1; tick(); load = 1'b0;
    repeat (55) tick();
    chk("lz_d3_an", an_a, 4'hF);
    chk("nolz_d3_an", an_nz, 4'b0111);

    // Drop enable in digit 2 SHOW
    repeat (24) tick();
    chk("nolz_d2_an", an_nz, 4'b1011);
    enable = 1'b0; tick();
    chk("off_an", an_nz, 4'hF);
    chk("off_fd", fd_nz, 1'b0);
    enable = 1'b1; tick();
    chk("resume_blank", an_a, 4'hF);
    repeat (2) tick();
    chk("resume_an", an_a, 4'b1110);
    chk("resume_data", data_a, 4'h0);

    // Load exactly on the wrap cycle
    repeat (29) tick();
    value = 16'h9876; load = 1'b1; tick(); load = 1'b0;
    chk("wload_pend", pend_a, 1'b0);
    chk("wload_fd", fd_a, 1'b1);
    chk("wload_data", data_a, 4'h6);

    // All zero: only digit 0 lights
    tick();
    value = 16'h0000; load = 1'b1; tick(); load = 1'b0;
    repeat (32) tick();
    chk("zero_d0_an", an_a, 4'b1110);
    chk("zero_d0_data", data_a, 4'h0);
    repeat (8) tick();
    chk("zero_d1_an", an_a, 4'hF);

    // Asynchronous reset mid-SHOW with a pending value
    value = 16'h4321; load = 1'b1; tick(); load = 1'b0;
    chk("pre_rst_pend", pend_a, 1'b1);
    chk("pre_rst_an", an_nz, 4'b1101);
    rst_n = 1'b0;
    #1;
    chk("arst_an", an_nz, 4'hF);
    chk("arst_data", data_nz, 4'h0);
    chk("arst_pend", pend_a, 1'b0);
    tick();
    rst_n = 1'b1;

    // Random phase
    for (int k = 0; k < 4000; k++) begin
      if (enable) enable = ($urandom_range(0, 299) != 0);
      else        enable = ($urandom_range(0, 9) == 0);
      load = ($urandom_range(0, 24) == 0);
      rv = $urandom;
      value = rv[15:0] >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_arst_an", an_a, 4'hF);
        chk("rnd_arst_pend", pend_a, 1'b0);
      end
      tick();
      rst_n = 1'b1;
    end
    load = 1'b0;
    tick();
    cmp_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
